sensor_protocol_core: RTL
=========================

// Module: sensor_protocol_core
// PURPOSE
//  Generalised successor to the single-sensor FPGA protocol core.
//  Sits between the UART rx/tx pair and N DHT11-class sensor drivers, and decodes addressed requests.
//  Adds the following over the single-sensor core:
//   - selects one of N sensor channels per request;
//   - bounds every sensor access and inter-byte gap with timeouts;
//   - sends an error code when a sensor fails.
// PARAMETERS
//  ADDRESS        8'h00   address byte this node answers to
//  N_SENSORS      4       sensor channels, 1..16
//  SNS_TIMEOUT    2000000 max cycles from sensor start to done/error
//  RX_TIMEOUT     500000  max cycles between address byte and command byte
// PORTS
//  i_Clock      in   1           single clock for the whole block
//  i_Reset      in   1           synchronous, active-high reset
//  i_Rx_Data    in   8           received UART byte, valid while i_Rx_Done=1
//  i_Rx_Done    in   1           one-cycle pulse per received byte
//  i_Tx_Done    in   1           one-cycle pulse when the UART finishes a byte
//  i_Sns_Data   in   32*N_SENSORS  ch k at [32k+31:32k]: [7:0] T int, [15:8] T dec, [23:16] H int, [31:24] H dec
//  i_Sns_Done   in   N_SENSORS   per-channel read-complete pulse
//  i_Sns_Error  in   N_SENSORS   per-channel read-failure pulse
//  o_Tx_Data    out  8           byte to transmit; stable from the start pulse until i_Tx_Done
//  o_Tx_Start   out  1           one-cycle pulse requesting transmission of o_Tx_Data
//  o_Sns_Start  out  N_SENSORS   one-hot; held high until done, error or timeout
//  o_Busy       out  1           high in every state except IDLE
// BEHAVIOUR
//  Reset and ordering
//   - Reset: all outputs 0, state IDLE, all counters 0.
//   - Reset mid-transaction aborts immediately; no partial frame is completed.
//  Request frame: [addr][cmd]
//   - cmd[7:4] = sensor index; cmd[3:0] = request code.
//   - Request codes: 3 = status, 4 = temperature, 5 = humidity.
//  States
//   - IDLE: on i_Rx_Done, go to RX_CMD if the byte equals ADDRESS, otherwise SKIP.
//   - RX_CMD: the next i_Rx_Done latches cmd and moves to DECODE.
//     If RX_TIMEOUT cycles pass with no byte, return to IDLE silently.
//   - SKIP: the next i_Rx_Done (or an RX_TIMEOUT expiry) returns to IDLE with no response.
//   - DECODE (1 cycle): an invalid code or an index >= N_SENSORS queues the 1-byte response 8'h2F.
//     Otherwise assert o_Sns_Start[idx] and go to SNS_WAIT.
//   - SNS_WAIT: the timeout counter increments every cycle.
//     - i_Sns_Done[idx]: latch the int/dec bytes for the requested quantity.
//     - i_Sns_Error[idx]: status becomes 8'h1F.
//     - Counter reaches SNS_TIMEOUT-1 with no done/error: status becomes 8'h1E.
//     - Done and Error in the same cycle: Error wins.
//     - Pulses on channels other than idx are ignored.
//     - o_Sns_Start drops in the cycle after the terminating event.
//   - TX_CODE, TX_INT, TX_DEC, [TX_CHK]: each state pulses o_Tx_Start for 1 cycle, then waits for i_Tx_Done.
//     The response byte sequence is:
//     - status request:             8'h00 (ok), 8'h1F (error) or 8'h1E (timeout);
//     - temperature, sensor ok:     8'h02, int, dec;
//     - humidity, sensor ok:        8'h01, int, dec;
//     - temperature/humidity, fail: the status byte only.
//  Timing and edge cases
//   - The first o_Tx_Start fires exactly 1 cycle after the decision that ends DECODE or SNS_WAIT.
//   - An i_Tx_Done seen in the same cycle as o_Tx_Start is ignored (it belongs to the previous byte).
//   - i_Rx_Done while o_Busy=1 and not in RX_CMD/SKIP: the byte is dropped; no queueing.
//   - After the last i_Tx_Done, return to IDLE.
// CONFIGURATION
//  Optional feature: checksum, macro PROTO_CHECKSUM_EN.
//   - Defined: every response gets a trailing TX_CHK byte equal to the XOR of all preceding response bytes.
//     Example: 02,19,05 -> 1E. A single-byte 2F -> 2F.
//   - Undefined: no TX_CHK state; frames are exactly as listed above.
// STRUCTURE
//  Shared package/include sensor_proto_defs.vh holds:
//   - state encodings;
//   - request codes 03/04/05;
//   - response codes 00/01/02/1F/1E/2F.
//  Sub-module proto_timeout_counter (load, enable, expire), instantiated twice:
//   - RX inter-byte timeout, width $clog2(RX_TIMEOUT+1);
//   - sensor timeout, width $clog2(SNS_TIMEOUT+1).
// TESTING
//  Test 1: rx 00,24; ch2 done with data 0x00_3C_05_19.
//          Expect o_Sns_Start=4'b0100, then tx 02,19,05.
//  Test 2: rx 00,15; ch1 i_Sns_Error pulse.
//          Expect tx 1F only; o_Sns_Start low the next cycle.
//  Test 3: rx 00,53 with N_SENSORS=4.
//          Expect tx 2F; no o_Sns_Start.
//  Test 4: rx 07,04 then 00,04.
//          Expect the first pair ignored with no tx; the second pair starts ch0.
//  Test 5: rx 00,03 with SNS_TIMEOUT=16 and the sensor silent.
//          Expect tx 1E exactly 17 cycles after the start rises.
//  Test 6: i_Reset during TX_INT.
//          Expect all outputs 0 next cycle; a later 00,35 request completes normally.
//          With PROTO_CHECKSUM_EN, repeat Test 1 and expect tx 02,19,05,1E.

Source files
------------

// File: rtl/sensor_protocol_core_pkg.sv
// Shared state encodings, request/response codes and the request-code check.
// Pure definitions: no logic, no latency, no flow control.
// ST_TX_CHK exists only when PROTO_CHECKSUM_EN is defined.
package sensor_protocol_core_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RX_CMD,
    ST_SKIP,
    ST_DECODE,
    ST_SNS_WAIT,
    ST_TX_CODE,
    ST_TX_INT,
    ST_TX_DEC
`ifdef PROTO_CHECKSUM_EN
    , ST_TX_CHK
`endif
  } state_t;

  localparam logic [3:0] REQ_STATUS = 4'h3;
  localparam logic [3:0] REQ_TEMP   = 4'h4;
  localparam logic [3:0] REQ_HUM    = 4'h5;

  localparam logic [7:0] RSP_OK   = 8'h00;
  localparam logic [7:0] RSP_HUM  = 8'h01;
  localparam logic [7:0] RSP_TEMP = 8'h02;
  localparam logic [7:0] RSP_ERR  = 8'h1F;
  localparam logic [7:0] RSP_TMO  = 8'h1E;
  localparam logic [7:0] RSP_BAD  = 8'h2F;

  function automatic logic req_known(input logic [3:0] code);
    return (code == REQ_STATUS) || (code == REQ_TEMP) || (code == REQ_HUM);
  endfunction

endpackage

// File: rtl/sensor_protocol_core_if.sv
// UART byte handshake plus N sensor-driver channels between the core and its neighbours.
// master = UART/sensor side, slave = protocol core; no storage, zero latency.
// Backpressure is implicit: the core only accepts bytes when it is ready for them.
interface sensor_protocol_core_if #(
  parameter int N_SENSORS = 4
) ();
  logic [7:0]              rx_data;
  logic                    rx_done;
  logic                    tx_done;
  logic [7:0]              tx_data;
  logic                    tx_start;
  logic [32*N_SENSORS-1:0] sns_data;
  logic [N_SENSORS-1:0]    sns_done;
  logic [N_SENSORS-1:0]    sns_error;
  logic [N_SENSORS-1:0]    sns_start;
  logic                    busy;

  modport master (
    output rx_data, rx_done, tx_done, sns_data, sns_done, sns_error,
    input  tx_data, tx_start, sns_start, busy
  );

  modport slave (
    input  rx_data, rx_done, tx_done, sns_data, sns_done, sns_error,
    output tx_data, tx_start, sns_start, busy
  );
endinterface

// File: rtl/sensor_protocol_core_timeout.sv
// proto_timeout_counter: cycle counter that pulses o_Expire once LIMIT enabled cycles have elapsed.
// Latency: o_Expire is registered, high in the cycle after the count reaches LIMIT-1.
// No backpressure; i_Load clears the count and any pending expiry.
module proto_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Load,
  input  logic i_Enable,
  output logic o_Expire
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge i_Clock) begin
    if (i_Reset || i_Load) begin
      count    <= '0;
      o_Expire <= 1'b0;
    end else if (i_Enable) begin
      o_Expire <= (count == W'(LIMIT - 1));
      // saturate so a lingering enable never wraps into a second expiry
      if (count != W'(LIMIT - 1)) count <= count + 1'b1;
    end else begin
      o_Expire <= 1'b0;
    end
  end
endmodule

// File: rtl/sensor_protocol_core.sv
// Addressed [addr][cmd] request decoder driving N sensor channels and a UART tx; PROTO_CHECKSUM_EN adds an XOR trailer byte.
// Latency: first tx byte starts 1 cycle after DECODE/SNS_WAIT decides; sensor and rx gaps bounded by timeouts.
// Backpressure: waits on tx_done per byte; rx bytes arriving while busy elsewhere are dropped.
module sensor_protocol_core
  import sensor_protocol_core_pkg::*;
#(
  parameter logic [7:0] ADDRESS     = 8'h00,
  parameter int         N_SENSORS   = 4,
  parameter int         SNS_TIMEOUT = 2000000,
  parameter int         RX_TIMEOUT  = 500000
) (
  input logic                  i_Clock,
  input logic                  i_Reset,
  sensor_protocol_core_if.slave bus
);

  state_t               state;
  logic [7:0]           cmd;
  logic [3:0]           idx;
  logic [7:0]           code_q, int_q, dec_q;
  logic                 multi_q;
  logic [7:0]           tx_data_q;
  logic                 tx_start_q;
  logic [N_SENSORS-1:0] sns_start_q;
  logic                 busy_q;

  assign idx           = cmd[7:4];
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.sns_start = sns_start_q;
  assign bus.busy      = busy_q;

  logic rx_load, rx_en, rx_expire, sns_load, sns_en, sns_expire;
  assign rx_load  = (state == ST_IDLE);
  assign rx_en    = (state == ST_RX_CMD) || (state == ST_SKIP);
  assign sns_load = (state == ST_DECODE);
  assign sns_en   = (state == ST_SNS_WAIT);

  proto_timeout_counter #(.LIMIT(RX_TIMEOUT)) u_rx_tmo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Load  (rx_load),
    .i_Enable(rx_en),
    .o_Expire(rx_expire)
  );

  proto_timeout_counter #(.LIMIT(SNS_TIMEOUT)) u_sns_tmo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Load  (sns_load),
    .i_Enable(sns_en),
    .o_Expire(sns_expire)
  );

  logic                 sel_done, sel_err;
  logic [31:0]          sel_word;
  logic [N_SENSORS-1:0] sel_onehot;

  always_comb begin
    sel_done   = 1'b0;
    sel_err    = 1'b0;
    sel_word   = '0;
    sel_onehot = '0;
    for (int k = 0; k < N_SENSORS; k++) begin
      if (idx == 4'(k)) begin
        sel_done      = bus.sns_done[k];
        sel_err       = bus.sns_error[k];
        sel_word      = bus.sns_data[32*k +: 32];
        sel_onehot[k] = 1'b1;
      end
    end
  end

  logic       req_ok;
  logic       sns_end;
  logic [7:0] rsp_code, rsp_int, rsp_dec;
  logic       rsp_multi;

  assign req_ok  = req_known(cmd[3:0]) && (int'(idx) < N_SENSORS);
  assign sns_end = sel_err || sel_done || sns_expire;

  // Error outranks done, and a real completion outranks a coincident timeout.
  always_comb begin
    rsp_code  = RSP_TMO;
    rsp_int   = 8'h00;
    rsp_dec   = 8'h00;
    rsp_multi = 1'b0;
    if (sel_err) begin
      rsp_code = RSP_ERR;
    end else if (sel_done) begin
      case (cmd[3:0])
        REQ_TEMP: begin
          rsp_code  = RSP_TEMP;
          rsp_int   = sel_word[7:0];
          rsp_dec   = sel_word[15:8];
          rsp_multi = 1'b1;
        end
        REQ_HUM: begin
          rsp_code  = RSP_HUM;
          rsp_int   = sel_word[23:16];
          rsp_dec   = sel_word[31:24];
          rsp_multi = 1'b1;
        end
        default: rsp_code = RSP_OK;
      endcase
    end
  end

`ifdef PROTO_CHECKSUM_EN
  logic [7:0] chk_byte;
  assign chk_byte = multi_q ? (code_q ^ int_q ^ dec_q) : code_q;
`endif

  // A tx_done coinciding with our own start pulse belongs to the previous byte.
  logic tx_ack;
  assign tx_ack = bus.tx_done && !tx_start_q;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state       <= ST_IDLE;
      cmd         <= '0;
      code_q      <= '0;
      int_q       <= '0;
      dec_q       <= '0;
      multi_q     <= 1'b0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      sns_start_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state)
        ST_IDLE: if (bus.rx_done) begin
          busy_q <= 1'b1;
          state  <= (bus.rx_data == ADDRESS) ? ST_RX_CMD : ST_SKIP;
        end
        ST_RX_CMD: begin
          if (bus.rx_done) begin
            cmd   <= bus.rx_data;
            state <= ST_DECODE;
          end else if (rx_expire) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_SKIP: if (bus.rx_done || rx_expire) begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        ST_DECODE: begin
          if (req_ok) begin
            sns_start_q <= sel_onehot;
            state       <= ST_SNS_WAIT;
          end else begin
            code_q     <= RSP_BAD;
            multi_q    <= 1'b0;
            tx_data_q  <= RSP_BAD;
            tx_start_q <= 1'b1;
            state      <= ST_TX_CODE;
          end
        end
        ST_SNS_WAIT: if (sns_end) begin
          sns_start_q <= '0;
          code_q      <= rsp_code;
          int_q       <= rsp_int;
          dec_q       <= rsp_dec;
          multi_q     <= rsp_multi;
          tx_data_q   <= rsp_code;
          tx_start_q  <= 1'b1;
          state       <= ST_TX_CODE;
        end
        ST_TX_CODE: if (tx_ack) begin
          if (multi_q) begin
            tx_data_q  <= int_q;
            tx_start_q <= 1'b1;
            state      <= ST_TX_INT;
          end else begin
`ifdef PROTO_CHECKSUM_EN
            tx_data_q  <= chk_byte;
            tx_start_q <= 1'b1;
            state      <= ST_TX_CHK;
`else
            busy_q <= 1'b0;
            state  <= ST_IDLE;
`endif
          end
        end
        ST_TX_INT: if (tx_ack) begin
          tx_data_q  <= dec_q;
          tx_start_q <= 1'b1;
          state      <= ST_TX_DEC;
        end
        ST_TX_DEC: if (tx_ack) begin
`ifdef PROTO_CHECKSUM_EN
          tx_data_q  <= chk_byte;
          tx_start_q <= 1'b1;
          state      <= ST_TX_CHK;
`else
          busy_q <= 1'b0;
          state  <= ST_IDLE;
`endif
        end
`ifdef PROTO_CHECKSUM_EN
        ST_TX_CHK: if (tx_ack) begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
`endif
        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
